dcache_mshr: RTL and testbench
==============================

// Module: dcache_mshr
// PURPOSE
//  Non-blocking data cache and miss-handling unit directly downstream of the memory stage's mmio port.
//  Resolves load hits combinationally in the request cycle. Tracks up to 4 outstanding load misses in an
//  in-order MSHR FIFO, refills them one at a time from backing memory, and retires each refill back to the
//  memory stage. Stores are write-through, no-write-allocate.
// PARAMETERS
//  NUM_LINES   16  direct-mapped one-word lines; index = addr[$clog2(NUM_LINES)+1:2], tag = upper bits
//  MSHR_DEPTH  4   outstanding load misses; fixed at 4 to match the memory stage's dependency tracker
// PORTS
//  clk              in   1   clock
//  rst              in   1   asynchronous, active-high reset
//  mmio_req         in   1   memory-stage request valid (combinational from stage)
//  mmio_lw          in   1   1 = load, 0 = store
//  mmio_addr        in   32  byte address; addr[1:0] ignored
//  mmio_data_write  in   32  store data
//  mmio_regD        in   5   load destination register
//  mmio_data_read   out  32  load hit data, or refill data during retire
//  hit_ack          out  1   request accepted (load hit / store accepted)
//  miss_store       out  1   load miss accepted into MSHR this cycle
//  load_done_stall  out  1   refill retiring this cycle
//  passive_stall    out  1   request cannot be accepted this cycle
//  regD_done        out  5   destination register of the retiring refill
//  mem_req          out  1   backing-memory request, held until mem_gnt
//  mem_we           out  1   1 = write, 0 = read
//  mem_addr         out  32  word-aligned address
//  mem_wdata        out  32  write data
//  mem_gnt          in   1   request accepted; completes a write
//  mem_rvalid       in   1   read data valid, at least 1 cycle after gnt
//  mem_rdata        in   32  read data
// BEHAVIOUR
//  Reset:
//   - All line valid bits, MSHR entries, pointers and count = 0; FSM = IDLE.
//   - All outputs = 0.
//  FSM states: IDLE, RD_REQ, RD_WAIT, RETIRE, WR_REQ.
//   - IDLE -> RD_REQ: MSHR non-empty, mem_addr = head addr.
//   - IDLE -> WR_REQ: store accepted (see below).
//   - RD_REQ (mem_req=1, we=0): on mem_gnt -> RD_WAIT.
//   - RD_WAIT: on mem_rvalid, capture mem_rdata into ret_buf -> RETIRE.
//   - RETIRE (exactly 1 cycle):
//       load_done_stall=1, regD_done=head.rd, mmio_data_read=ret_buf;
//       write line (valid, tag, data); pop head -> IDLE.
//   - WR_REQ (mem_req=1, we=1): on mem_gnt -> IDLE.
//   - mem_rvalid outside RD_WAIT is ignored.
//  Request handling (combinational, same cycle). At most one of {hit_ack, miss_store, load_done_stall,
//  passive_stall} is high.
//   - RETIRE has priority: all other responses are 0 and mmio_req is ignored; the stage re-presents it.
//   - Load, tag hit: hit_ack=1, mmio_data_read = line data.
//   - Load miss, addr matches a valid MSHR entry (secondary miss): passive_stall=1.
//   - Load miss, count == MSHR_DEPTH: passive_stall=1.
//   - Load miss, otherwise: miss_store=1; push {addr[31:2], regD} at the clock edge.
//   - Store, FSM==IDLE and MSHR empty:
//       hit_ack=1; on tag hit update line data at the edge (no allocate on miss);
//       latch addr/data -> WR_REQ.
//   - Store, otherwise: passive_stall=1.
//   - Push and pop in the same cycle are impossible: RETIRE blocks requests.
//   - Count range 0..4; pointers wrap mod 4.
//   - mmio_data_read = 0 when neither hit_ack nor load_done_stall.
//  Latency:
//   - Load hit: 0 cycles.
//   - Miss: retire no earlier than 3 cycles after miss_store (RD_REQ, RD_WAIT, RETIRE) with 0-latency memory.
//  Reset mid-operation: mem_req drops immediately; in-flight memory response discarded; MSHR contents lost.
// TESTING
//  1. Load 0x100 rd=5 miss -> miss_store=1; next cycle mem_req=1 we=0 addr=0x100; gnt, then
//     rvalid rdata=0xCAFEBABE -> next cycle load_done_stall=1, regD_done=5, data=0xCAFEBABE;
//     reload 0x100 -> hit_ack=1 same cycle, data 0xCAFEBABE.
//  2. Four misses 0x200/0x204/0x208/0x20C with mem_gnt held 0 -> 4x miss_store.
//     Fifth miss 0x210 -> passive_stall until the first retire.
//     Retires occur in order with rd values 1,2,3,4.
//  3. Store 0x100 while MSHR holds one entry -> passive_stall.
//     After the retire -> hit_ack=1, mem_req we=1 wdata=0x12345678; load 0x100 then hits 0x12345678.
//  4. Miss 0x300 pending; load 0x300 rd=7 -> passive_stall=1, no second MSHR push.
//  5. Hold mmio_req load-hit during RETIRE cycle -> only load_done_stall=1; hit_ack follows next cycle.
//  6. Assert rst in RD_WAIT -> all outputs 0 the same cycle; later mem_rvalid pulse -> no load_done_stall.
//     Reload 0x100 -> miss_store (valid bits cleared).

Source files
------------

// File: rtl/dcache_mshr.sv
// rtl/dcache_mshr.sv - direct-mapped write-through data cache with an in-order load-miss MSHR
module dcache_mshr #(
    parameter int NUM_LINES  = 16,
    parameter int MSHR_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mmio_req,
    input  logic        mmio_lw,
    input  logic [31:0] mmio_addr,
    input  logic [31:0] mmio_data_write,
    input  logic [4:0]  mmio_regD,
    output logic [31:0] mmio_data_read,
    output logic        hit_ack,
    output logic        miss_store,
    output logic        load_done_stall,
    output logic        passive_stall,
    output logic [4:0]  regD_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 30 - IDX_W;
    localparam int PTR_W = $clog2(MSHR_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, RETIRE, WR_REQ} state_t;
    state_t state_q, state_d;

    logic [NUM_LINES-1:0]  line_vld_q;
    logic [TAG_W-1:0]      line_tag_q  [NUM_LINES];
    logic [31:0]           line_data_q [NUM_LINES];

    logic [MSHR_DEPTH-1:0] mshr_vld_q;
    logic [29:0]           mshr_addr_q [MSHR_DEPTH];
    logic [4:0]            mshr_rd_q   [MSHR_DEPTH];
    logic [PTR_W-1:0]      head_q, tail_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [31:0]           ret_buf_q;
    logic [29:0]           wr_addr_q;
    logic [31:0]           wr_data_q;

    logic [29:0]      req_word;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [29:0]      head_word;
    logic [IDX_W-1:0] head_idx;
    logic [TAG_W-1:0] head_tag;
    logic             unused_byte_offset;

    assign req_word  = mmio_addr[31:2];
    assign req_idx   = req_word[IDX_W-1:0];
    assign req_tag   = req_word[29:IDX_W];
    assign head_word = mshr_addr_q[head_q];
    assign head_idx  = head_word[IDX_W-1:0];
    assign head_tag  = head_word[29:IDX_W];
    assign unused_byte_offset = ^mmio_addr[1:0];

    logic line_hit, mshr_match, retire, req_ok;
    logic load_hit, push, store_ok, stall;

    always_comb begin
        mshr_match = 1'b0;
        for (int i = 0; i < MSHR_DEPTH; i++) begin
            if (mshr_vld_q[i] && (mshr_addr_q[i] == req_word)) begin
                mshr_match = 1'b1;
            end
        end
    end

    // A retiring refill owns the response port; the stage re-presents its request next cycle.
    assign line_hit = line_vld_q[req_idx] && (line_tag_q[req_idx] == req_tag);
    assign retire   = (state_q == RETIRE);
    assign req_ok   = mmio_req && !rst && !retire;
    assign load_hit = req_ok && mmio_lw && line_hit;
    assign push     = req_ok && mmio_lw && !line_hit && !mshr_match && (cnt_q != CNT_W'(MSHR_DEPTH));
    assign store_ok = req_ok && !mmio_lw && (state_q == IDLE) && (cnt_q == '0);
    assign stall    = req_ok && !load_hit && !push && !store_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (store_ok) begin
                    state_d = WR_REQ;
                end else if ((cnt_q != '0) || push) begin
                    state_d = RD_REQ;
                end
            end
            RD_REQ:  if (mem_gnt) state_d = RD_WAIT;
            RD_WAIT: if (mem_rvalid) state_d = RETIRE;
            RETIRE:  state_d = IDLE;
            WR_REQ:  if (mem_gnt) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mmio_data_read  = '0;
        hit_ack         = 1'b0;
        miss_store      = 1'b0;
        load_done_stall = 1'b0;
        passive_stall   = 1'b0;
        regD_done       = '0;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        if (!rst) begin
            case (state_q)
                RD_REQ: begin
                    mem_req  = 1'b1;
                    mem_addr = {head_word, 2'b00};
                end
                WR_REQ: begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = {wr_addr_q, 2'b00};
                    mem_wdata = wr_data_q;
                end
                RETIRE: begin
                    load_done_stall = 1'b1;
                    regD_done       = mshr_rd_q[head_q];
                    mmio_data_read  = ret_buf_q;
                end
                default: ;
            endcase
            hit_ack       = load_hit || store_ok;
            miss_store    = push;
            passive_stall = stall;
            if (load_hit) begin
                mmio_data_read = line_data_q[req_idx];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_vld_q <= '0;
            mshr_vld_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
            ret_buf_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            for (int i = 0; i < MSHR_DEPTH; i++) begin
                mshr_addr_q[i] <= '0;
                mshr_rd_q[i]   <= '0;
            end
        end else begin
            if (push) begin
                mshr_vld_q[tail_q]  <= 1'b1;
                mshr_addr_q[tail_q] <= req_word;
                mshr_rd_q[tail_q]   <= mmio_regD;
                tail_q              <= tail_q + 1'b1;
                cnt_q               <= cnt_q + 1'b1;
            end else if (retire) begin
                mshr_vld_q[head_q]   <= 1'b0;
                line_vld_q[head_idx] <= 1'b1;
                head_q               <= head_q + 1'b1;
                cnt_q                <= cnt_q - 1'b1;
            end
            if ((state_q == RD_WAIT) && mem_rvalid) begin
                ret_buf_q <= mem_rdata;
            end
            if (store_ok) begin
                wr_addr_q <= req_word;
                wr_data_q <= mmio_data_write;
            end
        end
    end

    // Line payload needs no reset: the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (retire && !rst) begin
            line_tag_q[head_idx]  <= head_tag;
            line_data_q[head_idx] <= ret_buf_q;
        end else if (store_ok && line_hit) begin
            line_data_q[req_idx] <= mmio_data_write;
        end
    end
endmodule

// File: tb/tb_dcache_mshr.sv
// tb/tb_dcache_mshr.sv - self-checking bench for dcache_mshr
module tb_dcache_mshr;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, mmio_req, mmio_lw;
    logic [31:0] mmio_addr, mmio_data_write;
    logic [4:0]  mmio_regD;
    logic [31:0] mmio_data_read;
    logic        hit_ack, miss_store, load_done_stall, passive_stall;
    logic [4:0]  regD_done;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    dcache_mshr #(.NUM_LINES(16), .MSHR_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .mmio_req(mmio_req), .mmio_lw(mmio_lw), .mmio_addr(mmio_addr),
        .mmio_data_write(mmio_data_write), .mmio_regD(mmio_regD),
        .mmio_data_read(mmio_data_read), .hit_ack(hit_ack), .miss_store(miss_store),
        .load_done_stall(load_done_stall), .passive_stall(passive_stall), .regD_done(regD_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [106:0] outs();
        return {hit_ack, miss_store, load_done_stall, passive_stall, regD_done, mmio_data_read,
                mem_req, mem_we, mem_addr, mem_wdata};
    endfunction

    function automatic logic [3:0] resp();
        return {hit_ack, miss_store, load_done_stall, passive_stall};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic lw, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd, input logic gnt, input logic rv, input logic [31:0] rdata);
        mmio_req = req; mmio_lw = lw; mmio_addr = addr; mmio_data_write = wd; mmio_regD = rd;
        mem_gnt = gnt; mem_rvalid = rv; mem_rdata = rdata;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // One record per cycle; resp = {hit_ack, miss_store, load_done_stall, passive_stall}, mem = {mem_req, mem_we}.
    typedef struct {
        logic req, lw; logic [31:0] addr, wd; logic [4:0] rd; logic gnt, rv; logic [31:0] rdata;
        logic [3:0] e_resp; logic [4:0] e_rd; logic [31:0] e_data; logic [1:0] e_mem;
        logic [31:0] e_maddr, e_mwd;
    } vec_t;

    function automatic vec_t mk(input logic req, input logic lw, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [4:0] rd, input logic gnt, input logic rv, input logic [31:0] rdata,
                                input logic [3:0] e_resp, input logic [4:0] e_rd, input logic [31:0] e_data,
                                input logic [1:0] e_mem, input logic [31:0] e_maddr, input logic [31:0] e_mwd);
        vec_t v;
        v.req = req; v.lw = lw; v.addr = addr; v.wd = wd; v.rd = rd; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
        v.e_resp = e_resp; v.e_rd = e_rd; v.e_data = e_data; v.e_mem = e_mem; v.e_maddr = e_maddr; v.e_mwd = e_mwd;
        return v;
    endfunction

    localparam int NV = 17;
    vec_t vecs [NV];

    // Reference model: a word-addressed cache image, a miss queue and the current memory job.
    typedef struct {bit [29:0] word; bit [4:0] rd;} ment_t;
    bit          c_vld  [16];
    bit [29:0]   c_word [16];
    bit [31:0]   c_data [16];
    ment_t       mq [$];
    int          m_job;
    bit          m_granted, m_have, m_retire, m_push, m_store, m_hit;
    bit [31:0]   m_retbuf, m_wdata;
    bit [29:0]   m_wword, m_word;
    int          m_idx;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) c_vld[i] = 1'b0;
        mq.delete();
        m_job = 0; m_granted = 1'b0; m_have = 1'b0;
    endtask

    task automatic model_eval(output logic [106:0] e);
        logic ha, ms, lds, ps, mreq, mwe;
        logic [4:0] rdd;
        logic [31:0] rdat, maddr, mwd;
        bit found;
        ha = 0; ms = 0; lds = 0; ps = 0; mreq = 0; mwe = 0; rdd = 0; rdat = 0; maddr = 0; mwd = 0;
        m_push = 0; m_store = 0; m_hit = 0;
        m_word = mmio_addr[31:2];
        m_idx = int'(m_word % 30'd16);
        m_retire = (m_job == 1) && m_have;
        if (m_retire) begin
            lds = 1; rdd = mq[0].rd; rdat = m_retbuf;
        end
        if (m_job == 1 && !m_granted) begin
            mreq = 1; maddr = {mq[0].word, 2'b00};
        end
        if (m_job == 2) begin
            mreq = 1; mwe = 1; maddr = {m_wword, 2'b00}; mwd = m_wdata;
        end
        if (mmio_req && !m_retire) begin
            m_hit = c_vld[m_idx] && (c_word[m_idx] == m_word);
            found = 0;
            foreach (mq[i]) if (mq[i].word == m_word) found = 1;
            if (mmio_lw) begin
                if (m_hit) begin
                    ha = 1; rdat = c_data[m_idx];
                end else if (found || mq.size() >= 4) begin
                    ps = 1;
                end else begin
                    ms = 1; m_push = 1;
                end
            end else if (m_job == 0 && mq.size() == 0) begin
                ha = 1; m_store = 1;
            end else begin
                ps = 1;
            end
        end
        e = {ha, ms, lds, ps, rdd, rdat, mreq, mwe, maddr, mwd};
    endtask

    task automatic model_step();
        int li;
        ment_t ent;
        if (m_retire) begin
            li = int'(mq[0].word % 30'd16);
            c_vld[li] = 1; c_word[li] = mq[0].word; c_data[li] = m_retbuf;
            mq.delete(0);
            m_job = 0; m_granted = 0; m_have = 0;
        end else if (m_job == 1) begin
            if (!m_granted) begin
                if (mem_gnt) m_granted = 1;
            end else if (mem_rvalid) begin
                m_have = 1; m_retbuf = mem_rdata;
            end
        end else if (m_job == 2) begin
            if (mem_gnt) m_job = 0;
        end else if (m_store) begin
            m_job = 2; m_wword = m_word; m_wdata = mmio_data_write;
            if (m_hit) c_data[m_idx] = mmio_data_write;
        end else if (mq.size() != 0 || m_push) begin
            m_job = 1;
        end
        if (m_push) begin
            ent.word = m_word; ent.rd = mmio_regD;
            mq.push_back(ent);
        end
    endtask

    logic [31:0]  pool [8];
    logic [106:0] exp_o;
    int           retires, ms_at;

    initial begin
        vecs[0]  = mk(1, 1, 32'h100, 0, 5'd5, 0, 0, 0,            4'b0100, 0, 0,            2'b00, 0, 0);
        vecs[1]  = mk(0, 0, 0,       0, 5'd0, 1, 0, 0,            4'b0000, 0, 0,            2'b10, 32'h100, 0);
        vecs[2]  = mk(0, 0, 0,       0, 5'd0, 0, 1, 32'hCAFEBABE, 4'b0000, 0, 0,            2'b00, 0, 0);
        vecs[3]  = mk(1, 1, 32'h100, 0, 5'd9, 0, 0, 0,            4'b0010, 5, 32'hCAFEBABE, 2'b00, 0, 0);
        vecs[4]  = mk(1, 1, 32'h100, 0, 5'd9, 0, 0, 0,            4'b1000, 0, 32'hCAFEBABE, 2'b00, 0, 0);
        vecs[5]  = mk(1, 0, 32'h100, 32'h12345678, 5'd0, 0, 0, 0, 4'b1000, 0, 0,            2'b00, 0, 0);
        vecs[6]  = mk(1, 1, 32'h100, 0, 5'd2, 0, 0, 0,            4'b1000, 0, 32'h12345678, 2'b11, 32'h100, 32'h12345678);
        vecs[7]  = mk(1, 0, 32'h104, 32'hDEAD, 5'd0, 1, 0, 0,     4'b0001, 0, 0,            2'b11, 32'h100, 32'h12345678);
        vecs[8]  = mk(1, 1, 32'h104, 0, 5'd3, 0, 0, 0,            4'b0100, 0, 0,            2'b00, 0, 0);
        vecs[9]  = mk(1, 1, 32'h104, 0, 5'd3, 0, 0, 0,            4'b0001, 0, 0,            2'b10, 32'h104, 0);
        vecs[10] = mk(1, 0, 32'h200, 32'h1, 5'd0, 1, 0, 0,        4'b0001, 0, 0,            2'b10, 32'h104, 0);
        vecs[11] = mk(0, 0, 0,       0, 5'd0, 0, 0, 0,            4'b0000, 0, 0,            2'b00, 0, 0);
        vecs[12] = mk(0, 0, 0,       0, 5'd0, 0, 1, 32'hA5A50001, 4'b0000, 0, 0,            2'b00, 0, 0);
        vecs[13] = mk(0, 0, 0,       0, 5'd0, 0, 0, 0,            4'b0010, 3, 32'hA5A50001, 2'b00, 0, 0);
        vecs[14] = mk(1, 1, 32'h104, 0, 5'd3, 0, 0, 0,            4'b1000, 0, 32'hA5A50001, 2'b00, 0, 0);
        vecs[15] = mk(1, 1, 32'h106, 0, 5'd3, 0, 0, 0,            4'b1000, 0, 32'hA5A50001, 2'b00, 0, 0);
        vecs[16] = mk(1, 1, 32'h144, 0, 5'd4, 0, 0, 0,            4'b0100, 0, 0,            2'b00, 0, 0);
        pool = '{32'h100, 32'h140, 32'h104, 32'h144, 32'h108, 32'h3C8, 32'h10C, 32'h8000010C};

        rst = 1'b1;
        drive(1'b1, 1'b1, 32'h100, 32'h0, 5'd1, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", 128'(outs()), 128'(0));
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].req, vecs[i].lw, vecs[i].addr, vecs[i].wd, vecs[i].rd,
                  vecs[i].gnt, vecs[i].rv, vecs[i].rdata);
            @(negedge clk);
            check($sformatf("vec%0d_resp", i),  128'(resp()),             128'(vecs[i].e_resp));
            check($sformatf("vec%0d_rd", i),    128'(regD_done),          128'(vecs[i].e_rd));
            check($sformatf("vec%0d_data", i),  128'(mmio_data_read),     128'(vecs[i].e_data));
            check($sformatf("vec%0d_mem", i),   128'({mem_req, mem_we}),  128'(vecs[i].e_mem));
            check($sformatf("vec%0d_maddr", i), 128'(mem_addr),           128'(vecs[i].e_maddr));
            check($sformatf("vec%0d_mwd", i),   128'(mem_wdata),          128'(vecs[i].e_mwd));
            step();
        end

        // Reset while a refill waits for read data.
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("t6_rdreq", 128'({mem_req, mem_we, mem_addr}), 128'({1'b1, 1'b0, 32'h144}));
        step();
        drive(1'b1, 1'b1, 32'h100, 32'h0, 5'd1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("t6_hit_before_rst", 128'({resp(), mmio_data_read}), 128'({4'b1000, 32'h12345678}));
        #1 rst = 1'b1;
        #1;
        check("t6_rst_outs", 128'(outs()), 128'(0));
        step();
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 32'hBAD0BAD0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_after_rst", 128'(outs()), 128'(0));
            step();
        end
        drive(1'b1, 1'b1, 32'h100, 32'h0, 5'd2, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("t6_reload_miss", 128'(resp()), 128'(4'b0100));
        step();

        // Fill the MSHR, stall a fifth miss, then drain in order.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 32'h200 + 32'(4 * i), 32'h0, 5'(i + 1), 1'b0, 1'b0, 32'h0);
            @(negedge clk);
            check("t2_miss", 128'(resp()), 128'(4'b0100));
            step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'h210, 32'h0, 5'd5, 1'b0, 1'b0, 32'h0);
            @(negedge clk);
            check("t2_full", 128'(resp()), 128'(4'b0001));
            step();
        end
        retires = 0;
        ms_at = -1;
        for (int cyc = 0; cyc < 200 && retires < 5; cyc++) begin
            drive(ms_at < 0, 1'b1, 32'h210, 32'h0, 5'd5, 1'b1, 1'b1, 32'hD0000000 + 32'(retires));
            @(negedge clk);
            if (load_done_stall) begin
                check("t2_retire_rd", 128'(regD_done), 128'(retires + 1));
                check("t2_retire_data", 128'(mmio_data_read), 128'(32'hD0000000 + 32'(retires)));
                retires++;
            end else if (miss_store) begin
                ms_at = retires;
            end
            step();
        end
        check("t2_retire_count", 128'(retires), 128'(5));
        check("t2_fifth_accepted_after", 128'(ms_at), 128'(1));

        // Random traffic against the reference model.
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                  pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3)), $urandom,
                  5'($urandom_range(0, 31)), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
            model_eval(exp_o);
            @(negedge clk);
            check("rand_outs", 128'(outs()), 128'(exp_o));
            model_step();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
